game_scheduler: RTL and testbench

//  Central sequencer between the button front-end, the game instances and sevenseg_driver.
//  - Owns the active-game selection.
//  - Routes debounced button pulses only to the active game.
//  - Shows a game-number splash after every switch.
//  - Arbitrates the single 4-bit display value fed to the segment driver.

---
 rtl/game_scheduler.sv | 109 ++++++++++
 tb/tb_game_scheduler.sv | 115 +++++++++++
 2 files changed

// File: rtl/game_scheduler.sv
// game_scheduler: owns active-game selection, routes button pulses, shows a switch splash and arbitrates the display.
// Optional IDLE_BLANK_EN adds an idle-blanking state; the default build has no BLANK state.
module game_scheduler #(
  parameter int NUM_GAMES     = 3,
  parameter int SPLASH_CYCLES = 1_000_000,
  parameter int IDLE_CYCLES   = 50_000_000,
  parameter int CNT_W         = 26
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [3:0]             btn_pulse_i,
  input  logic                   switch_pulse_i,
  input  logic [4*NUM_GAMES-1:0] game_values_i,
  output logic [4*NUM_GAMES-1:0] game_btn_o,
  output logic [1:0]             game_sel_o,
  output logic [3:0]             display_value_o,
  output logic                   splash_active_o
);
`ifdef IDLE_BLANK_EN
  typedef enum logic [1:0] {RUN, SPLASH, BLANK} state_t;
`else
  typedef enum logic [1:0] {RUN, SPLASH} state_t;
`endif
  localparam logic [1:0]       LAST        = 2'(NUM_GAMES - 1);
  localparam logic [CNT_W-1:0] SPLASH_LOAD = CNT_W'(SPLASH_CYCLES - 1);
  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d, sel_nxt;
  logic [CNT_W-1:0] tmr_q, tmr_d;
  logic [3:0]       cur_val;
`ifdef IDLE_BLANK_EN
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
  logic [CNT_W-1:0] idle_q, idle_d;
  logic             any_pulse;
  assign any_pulse = |btn_pulse_i | switch_pulse_i;
`endif
  assign sel_nxt    = (sel_q == LAST) ? 2'd0 : sel_q + 2'd1;
  assign game_sel_o = sel_q;
  always_comb begin
    cur_val = '0;
    for (int g = 0; g < NUM_GAMES; g++)
      if (2'(g) == sel_q) cur_val = game_values_i[4*g +: 4];
  end
  always_comb begin
    state_d         = state_q;
    sel_d           = sel_q;
    tmr_d           = tmr_q;
    game_btn_o      = '0;
    display_value_o = cur_val;
    splash_active_o = 1'b0;
`ifdef IDLE_BLANK_EN
    idle_d          = '0;
`endif
    case (state_q)
      RUN: begin
        if (switch_pulse_i) begin
          sel_d   = sel_nxt;
          tmr_d   = SPLASH_LOAD;
          state_d = SPLASH;
        end else begin
          for (int g = 0; g < NUM_GAMES; g++)
            if (2'(g) == sel_q) game_btn_o[4*g +: 4] = btn_pulse_i;
`ifdef IDLE_BLANK_EN
          // idle counter wraps to 0 on the cycle it hands over to BLANK
          if (!any_pulse) begin
            idle_d  = (idle_q == IDLE_LAST) ? '0 : idle_q + 1'b1;
            state_d = (idle_q == IDLE_LAST) ? BLANK : RUN;
          end
`endif
        end
      end
      SPLASH: begin
        display_value_o = {2'b00, sel_q} + 4'd1;
        splash_active_o = 1'b1;
        if (switch_pulse_i) begin
          sel_d = sel_nxt;
          tmr_d = SPLASH_LOAD;
        end else if (tmr_q == '0) begin
          state_d = RUN;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
`ifdef IDLE_BLANK_EN
      BLANK: begin
        display_value_o = 4'd12;
        state_d         = any_pulse ? RUN : BLANK;
      end
`endif
      default: state_d = RUN;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      sel_q   <= 2'd0;
      tmr_q   <= '0;
`ifdef IDLE_BLANK_EN
      idle_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      tmr_q   <= tmr_d;
`ifdef IDLE_BLANK_EN
      idle_q  <= idle_d;
`endif
    end
  end
endmodule

// File: tb/tb_game_scheduler.sv
// tb_game_scheduler: scoreboard bench; a cycle-level game/splash/idle model feeds an expectation queue drained by a monitor.
module tb_game_scheduler;
  localparam int NG = 3, SC = 4, IC = 10;
  logic        clk = 1'b0, rst_n = 1'b0, sw = 1'b0;
  logic [3:0]  btn = '0;
  logic [11:0] vals = 12'h735;
  logic [11:0] gb;
  logic [1:0]  sel;
  logic [3:0]  disp;
  logic        sp;
  game_scheduler #(.NUM_GAMES(NG), .SPLASH_CYCLES(SC), .IDLE_CYCLES(IC), .CNT_W(26)) dut (
    .clk(clk), .rst_n(rst_n), .btn_pulse_i(btn), .switch_pulse_i(sw), .game_values_i(vals),
    .game_btn_o(gb), .game_sel_o(sel), .display_value_o(disp), .splash_active_o(sp));
  always #5 clk = ~clk;
  typedef struct packed {logic [11:0] gb; logic [1:0] sel; logic [3:0] disp; logic sp;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  int game = 0, splash_left = 0, idle = 0;
  bit blanked = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({gb, sel, disp, sp} !== e) begin
        errors++;
        $display("FAIL scoreboard t=%0t got gb=%h sel=%0d disp=%0d sp=%b exp gb=%h sel=%0d disp=%0d sp=%b",
                 $time, gb, sel, disp, sp, e.gb, e.sel, e.disp, e.sp);
      end
    end
  end
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", n, got, exp);
    end
  endtask
  task automatic model_reset();
    game = 0; splash_left = 0; idle = 0; blanked = 1'b0;
  endtask
  task automatic cyc(input logic [3:0] b, input logic s);
    exp_t e;
    btn = b; sw = s;
    e.sel  = 2'(game);
    e.sp   = (splash_left > 0) && !blanked;
    e.disp = blanked ? 4'd12 : (splash_left > 0) ? 4'(game + 1) : 4'(vals >> (4 * game));
    e.gb   = (!blanked && splash_left == 0 && !s) ? (12'(b) << (4 * game)) : 12'h000;
    q.push_back(e);
    @(posedge clk);
    if (blanked) begin
      if (b != 0 || s) begin blanked = 1'b0; idle = 0; end
    end else if (splash_left > 0) begin
      if (s) begin game = (game + 1) % NG; splash_left = SC; end
      else splash_left--;
    end else if (s) begin
      game = (game + 1) % NG; splash_left = SC; idle = 0;
    end else if (b != 0) begin
      idle = 0;
    end else begin
`ifdef IDLE_BLANK_EN
      idle++;
      if (idle == IC) begin blanked = 1'b1; idle = 0; end
`endif
    end
    #1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_sel", 32'(sel), 32'd0);
    chk("reset_splash", 32'(sp), 32'd0);
    chk("reset_gb", 32'(gb), 32'd0);
    rst_n = 1'b1;
    cyc(4'b0001, 1'b0);
    cyc(4'b0000, 1'b1);
    repeat (4) cyc(4'b1111, 1'b0);
    cyc(4'b0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(4'b0000, 1'b1);
      repeat (4) cyc(4'b0000, 1'b0);
    end
    cyc(4'b0000, 1'b1);
    repeat (2) cyc(4'b0000, 1'b0);
    cyc(4'b0000, 1'b1);
    repeat (5) cyc(4'b0000, 1'b0);
    cyc(4'b0010, 1'b1);
    repeat (5) cyc(4'b0000, 1'b0);
    cyc(4'b0000, 1'b1);
    cyc(4'b0000, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_splash", 32'(sp), 32'd0);
    chk("async_rst_sel", 32'(sel), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
`ifdef IDLE_BLANK_EN
    repeat (12) cyc(4'b0000, 1'b0);
    cyc(4'b0100, 1'b0);
    repeat (2) cyc(4'b0000, 1'b0);
`else
    repeat (1000) cyc(4'b0000, 1'b0);
`endif
    repeat (2000) begin
      vals = 12'($urandom);
      cyc(($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000, $urandom_range(0, 9) == 0);
    end
    @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
